// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control-bundle types, forwarding selects and opcode constants
package ctrl_pkg;
    localparam int REG_W_DEF    = 5;
    localparam int ALUOP_W_DEF  = 4;
    localparam int WBI_REGWRITE = 1;
    localparam int WBI_SRCALU   = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    typedef struct packed {
        logic       valid;
        logic       isJump;
        logic       isNotConditional;
        logic       isEq;
        logic       memWrite;
        logic       memRead;
        logic       aluSrc;
        logic [1:0] wbi;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic writes(input logic valid, input logic reg_write, input logic dst_nz);
        return valid & reg_write & dst_nz;
    endfunction
endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: branch resolution, load-use/RAW stall and EX operand forwarding selects
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             id_valid,
    input  logic             id_regDst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_isJump,
    input  logic             ex_isNotConditional,
    input  logic             ex_isEq,
    input  logic             ex_memRead,
    input  logic             ex_writes,
    input  logic             ex_zero,
    input  logic [REG_W-1:0] ex_dst,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_writes,
    input  logic             mem_srcAlu,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_writes,
    input  logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    logic id_hit_ex, id_hit_mem, mem_fwd, wb_fwd;

    // Without forwarding any RAW on EX or MEM stalls; with it only a load in EX does
    always_comb begin
        branch_taken = ex_valid & ex_isJump & (ex_isNotConditional | (ex_zero ~^ ex_isEq));
        id_hit_ex    = ex_writes & (ex_dst == id_rs | (id_regDst & ex_dst == id_rt));
        id_hit_mem   = mem_writes & (mem_dst == id_rs | (id_regDst & mem_dst == id_rt));
        stall        = id_valid & ~branch_taken & (FWD_EN ? ex_memRead & id_hit_ex : id_hit_ex | id_hit_mem);
        mem_fwd      = FWD_EN & mem_writes & mem_srcAlu;
        wb_fwd       = FWD_EN & wb_writes;
        fwd_a        = (mem_fwd & ex_rs == mem_dst) ? FWD_MEM : (wb_fwd & ex_rs == wb_dst) ? FWD_WB : FWD_RF;
        fwd_b        = (mem_fwd & ex_rt == mem_dst) ? FWD_MEM : (wb_fwd & ex_rt == wb_dst) ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX->MEM->WB control pipeline registers with branch kill, load-use bubble and forwarding
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               id_valid,
    input  logic [ALUOP_W-1:0] id_aluOp,
    input  logic               id_isJump,
    input  logic               id_isNotConditional,
    input  logic               id_isEq,
    input  logic               id_memWrite,
    input  logic               id_memRead,
    input  logic               id_aluSrc,
    input  logic               id_regDst,
    input  logic [1:0]         id_wbi,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               ex_zero,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_aluOp,
    output logic               ex_aluSrc,
    output logic               ex_isJump,
    output logic               mem_valid,
    output logic               mem_memWrite,
    output logic               mem_memRead,
    output logic               wb_valid,
    output logic               wb_regWrite,
    output logic               wb_srcAlu,
    output logic [REG_W-1:0]   wb_dst,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               stall,
    output logic               flush,
    output logic               branch_taken
);
    ctrl_t              id_c, ex_c_d, ex_c_q;
    logic [ALUOP_W-1:0] ex_aluOp_d, ex_aluOp_q;
    logic [REG_W-1:0]   ex_dst_d, ex_dst_q, ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q;
    logic               mem_valid_q, mem_memWrite_q, mem_memRead_q;
    logic [1:0]         mem_wbi_q;
    logic [REG_W-1:0]   mem_dst_q, wb_dst_q;
    logic               wb_valid_q, wb_regWrite_q, wb_srcAlu_q;
    logic               kill, ex_writes, mem_writes, wb_writes;

    // EX next state: the decoded ID bundle, or an all-zero bubble on branch kill, stall or empty ID
    always_comb begin
        id_c       = '{valid: id_valid, isJump: id_isJump, isNotConditional: id_isNotConditional,
                       isEq: id_isEq, memWrite: id_memWrite, memRead: id_memRead,
                       aluSrc: id_aluSrc, wbi: id_wbi};
        kill       = branch_taken | stall | ~id_valid;
        ex_c_d     = kill ? CTRL_BUBBLE : id_c;
        ex_aluOp_d = kill ? '0 : id_aluOp;
        ex_dst_d   = kill ? '0 : (id_regDst ? id_rd : id_rt);
        ex_rs_d    = kill ? '0 : id_rs;
        ex_rt_d    = kill ? '0 : id_rt;
    end

    // Stage registers: async clear, frozen while hold is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_c_q         <= CTRL_BUBBLE;
            ex_aluOp_q     <= '0;
            ex_dst_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_memWrite_q <= 1'b0;
            mem_memRead_q  <= 1'b0;
            mem_wbi_q      <= '0;
            mem_dst_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_regWrite_q  <= 1'b0;
            wb_srcAlu_q    <= 1'b0;
            wb_dst_q       <= '0;
        end else if (!hold) begin
            ex_c_q         <= ex_c_d;
            ex_aluOp_q     <= ex_aluOp_d;
            ex_dst_q       <= ex_dst_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            mem_valid_q    <= ex_c_q.valid;
            mem_memWrite_q <= ex_c_q.memWrite;
            mem_memRead_q  <= ex_c_q.memRead;
            mem_wbi_q      <= ex_c_q.wbi;
            mem_dst_q      <= ex_dst_q;
            wb_valid_q     <= mem_valid_q;
            wb_regWrite_q  <= mem_wbi_q[WBI_REGWRITE];
            wb_srcAlu_q    <= mem_wbi_q[WBI_SRCALU];
            wb_dst_q       <= mem_dst_q;
        end
    end

    assign ex_writes  = writes(ex_c_q.valid, ex_c_q.wbi[WBI_REGWRITE], ex_dst_q != '0);
    assign mem_writes = writes(mem_valid_q, mem_wbi_q[WBI_REGWRITE], mem_dst_q != '0);
    assign wb_writes  = writes(wb_valid_q, wb_regWrite_q, wb_dst_q != '0);

    hazard_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_hazard (
        .id_valid            (id_valid),
        .id_regDst           (id_regDst),
        .id_rs               (id_rs),
        .id_rt               (id_rt),
        .ex_valid            (ex_c_q.valid),
        .ex_isJump           (ex_c_q.isJump),
        .ex_isNotConditional (ex_c_q.isNotConditional),
        .ex_isEq             (ex_c_q.isEq),
        .ex_memRead          (ex_c_q.memRead),
        .ex_writes           (ex_writes),
        .ex_zero             (ex_zero),
        .ex_dst              (ex_dst_q),
        .ex_rs               (ex_rs_q),
        .ex_rt               (ex_rt_q),
        .mem_writes          (mem_writes),
        .mem_srcAlu          (mem_wbi_q[WBI_SRCALU]),
        .mem_dst             (mem_dst_q),
        .wb_writes           (wb_writes),
        .wb_dst              (wb_dst_q),
        .stall               (stall),
        .branch_taken        (branch_taken),
        .fwd_a               (fwd_a),
        .fwd_b               (fwd_b)
    );

    assign flush        = branch_taken;
    assign ex_valid     = ex_c_q.valid;
    assign ex_aluOp     = ex_aluOp_q;
    assign ex_aluSrc    = ex_c_q.aluSrc;
    assign ex_isJump    = ex_c_q.isJump;
    assign mem_valid    = mem_valid_q;
    assign mem_memWrite = mem_memWrite_q;
    assign mem_memRead  = mem_memRead_q;
    assign wb_valid     = wb_valid_q;
    assign wb_regWrite  = wb_regWrite_q;
    assign wb_srcAlu    = wb_srcAlu_q;
    assign wb_dst       = wb_dst_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed-step bench for ctrl_pipe with immediate-assertion checks
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_aluOp = '0;
    logic       id_isJump = 1'b0, id_isNotConditional = 1'b0, id_isEq = 1'b0;
    logic       id_memWrite = 1'b0, id_memRead = 1'b0, id_aluSrc = 1'b0, id_regDst = 1'b0;
    logic [1:0] id_wbi = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_zero = 1'b0;
    logic       ex_valid, ex_aluSrc, ex_isJump, mem_valid, mem_memWrite, mem_memRead;
    logic [3:0] ex_aluOp;
    logic       wb_valid, wb_regWrite, wb_srcAlu, stall, flush, branch_taken;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a, fwd_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_isJump(id_isJump), .id_isNotConditional(id_isNotConditional), .id_isEq(id_isEq),
        .id_memWrite(id_memWrite), .id_memRead(id_memRead), .id_aluSrc(id_aluSrc),
        .id_regDst(id_regDst), .id_wbi(id_wbi), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_zero(ex_zero), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp), .ex_aluSrc(ex_aluSrc),
        .ex_isJump(ex_isJump), .mem_valid(mem_valid), .mem_memWrite(mem_memWrite),
        .mem_memRead(mem_memRead), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
        .wb_srcAlu(wb_srcAlu), .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .flush(flush), .branch_taken(branch_taken)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic j, input logic nc,
                         input logic eq, input logic mw, input logic mr, input logic as,
                         input logic rdst, input logic [1:0] wbi, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_aluOp = op; id_isJump = j; id_isNotConditional = nc; id_isEq = eq;
        id_memWrite = mw; id_memRead = mr; id_aluSrc = as; id_regDst = rdst; id_wbi = wbi;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1, 4'd2, 0, 0, 0, 0, 0, 0, 1, 2'b11, rs, rt, rd);
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
        drive(1, 4'd0, 0, 0, 0, 0, 1, 1, 0, 2'b10, rs, rt, 5'd0);
    endtask

    task automatic br(input logic [5:0] op);
        drive(1, 4'd1, 1, op == OP_J || op == OP_JAL, op == OP_BEQ, 0, 0, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0);
    endtask

    task automatic nop();
        drive(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // power-on reset
        @(negedge clk);
        chk("rst_ex_valid", 8'(ex_valid), 8'd0);
        chk("rst_wb_valid", 8'(wb_valid), 8'd0);
        chk("rst_wb_dst", 8'(wb_dst), 8'd0);
        chk("rst_fwd", 8'({fwd_a, fwd_b}), 8'd0);
        chk("rst_stall_br", 8'({stall, flush, branch_taken}), 8'd0);
        step();
        reset = 1'b0;
        // t0: ADD $3=$1+$2
        add(5'd3, 5'd1, 5'd2);
        @(negedge clk);
        chk("t0_ex_valid", 8'(ex_valid), 8'd0);
        step();
        // t1: EX=ADD3, ID=SUB $4=$3-$3
        add(5'd4, 5'd3, 5'd3);
        id_aluOp = 4'd6;
        @(negedge clk);
        chk("t1_ex_valid", 8'(ex_valid), 8'd1);
        chk("t1_ex_aluOp", 8'(ex_aluOp), 8'd2);
        chk("t1_fwd_a", 8'(fwd_a), 8'd0);
        step();
        // t2: EX=SUB4, MEM=ADD3 -> forward from MEM
        add(5'd5, 5'd3, 5'd3);
        @(negedge clk);
        chk("fwd_mem_a", 8'(fwd_a), 8'b01);
        chk("fwd_mem_b", 8'(fwd_b), 8'b01);
        chk("t2_ex_aluOp", 8'(ex_aluOp), 8'd6);
        step();
        // t3: EX=ADD5, WB=ADD3 -> forward from WB
        add(5'd0, 5'd1, 5'd2);
        @(negedge clk);
        chk("fwd_wb_a", 8'(fwd_a), 8'b10);
        chk("fwd_wb_b", 8'(fwd_b), 8'b10);
        chk("t3_wb", 8'({wb_valid, wb_regWrite, wb_srcAlu, wb_dst}), {3'b111, 5'd3});
        step();
        // t4: EX=ADD0, ID=ADD $6=$0+$0
        add(5'd6, 5'd0, 5'd0);
        step();
        // t5: EX=ADD6, MEM=ADD0 (dst 0), WB=ADD5
        lw(5'd8, 5'd1);
        @(negedge clk);
        chk("fwd_zero_a", 8'(fwd_a), 8'd0);
        chk("fwd_zero_b", 8'(fwd_b), 8'd0);
        chk("t5_wb_dst", 8'(wb_dst), 8'd5);
        step();
        // t6: EX=LW8, ID=ADD $9=$8+$2 -> load-use stall
        add(5'd9, 5'd8, 5'd2);
        @(negedge clk);
        chk("lu_stall", 8'(stall), 8'd1);
        chk("lu_ex_aluSrc", 8'(ex_aluSrc), 8'd1);
        chk("lu_br", 8'(branch_taken), 8'd0);
        step();
        // t7: bubble in EX, LW8 in MEM
        @(negedge clk);
        chk("lu_stall_once", 8'(stall), 8'd0);
        chk("lu_bubble", 8'(ex_valid), 8'd0);
        chk("lu_mem_rd", 8'({mem_valid, mem_memRead, mem_memWrite}), 8'b110);
        step();
        // t8: EX=ADD9, WB=LW8
        nop();
        @(negedge clk);
        chk("lu_fwd_a", 8'(fwd_a), 8'b10);
        chk("lu_fwd_b", 8'(fwd_b), 8'b00);
        chk("lu_ex_valid", 8'(ex_valid), 8'd1);
        chk("lu_wb", 8'({wb_valid, wb_srcAlu, wb_dst}), {2'b10, 5'd8});
        step();
        // t9: load into $0 followed by its use never stalls
        lw(5'd0, 5'd1);
        step();
        add(5'd10, 5'd0, 5'd0);
        @(negedge clk);
        chk("zero_no_stall", 8'(stall), 8'd0);
        step();
        nop();
        @(negedge clk);
        chk("zero_no_bubble", 8'(ex_valid), 8'd1);
        chk("zero_no_fwd", 8'({fwd_a, fwd_b}), 8'd0);
        br(OP_BEQ);
        step();
        // t12: BEQ in EX with zero=1 -> taken, ID instruction killed
        add(5'd11, 5'd1, 5'd2);
        ex_zero = 1'b1;
        @(negedge clk);
        chk("beq_taken", 8'(branch_taken), 8'd1);
        chk("beq_flush", 8'(flush), 8'd1);
        chk("beq_ex_isJump", 8'(ex_isJump), 8'd1);
        step();
        ex_zero = 1'b0;
        br(OP_BEQ);
        @(negedge clk);
        chk("beq_kill", 8'(ex_valid), 8'd0);
        chk("beq_one_cycle", 8'(branch_taken), 8'd0);
        chk("beq_mem", 8'(mem_valid), 8'd1);
        step();
        // t14: BEQ with zero=0 -> not taken
        add(5'd12, 5'd1, 5'd2);
        @(negedge clk);
        chk("beq_not_taken", 8'({branch_taken, flush}), 8'd0);
        step();
        br(OP_BNE);
        @(negedge clk);
        chk("beq_nt_ex_valid", 8'(ex_valid), 8'd1);
        step();
        // t16: BNE with zero=0 -> taken; with zero=1 -> not
        nop();
        @(negedge clk);
        chk("bne_taken", 8'(branch_taken), 8'd1);
        ex_zero = 1'b1;
        #1;
        chk("bne_not_taken", 8'(branch_taken), 8'd0);
        ex_zero = 1'b0;
        step();
        br(OP_J);
        step();
        // t18: J in EX with zero=0 -> taken; hold for 4 edges
        add(5'd13, 5'd1, 5'd2);
        hold = 1'b1;
        @(negedge clk);
        chk("j_taken", 8'({branch_taken, flush}), 8'b11);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("hold_br", 8'({branch_taken, flush, ex_isJump}), 8'b111);
            chk("hold_stages", 8'({ex_valid, mem_valid, wb_valid, wb_regWrite}), 8'b1010);
        end
        hold = 1'b0;
        step();
        @(negedge clk);
        chk("hold_resume", 8'({ex_valid, mem_valid, wb_valid, branch_taken}), 8'b0100);
        // reset with three instructions in flight
        step();
        add(5'd14, 5'd1, 5'd2);
        step();
        add(5'd15, 5'd1, 5'd2);
        step();
        add(5'd16, 5'd1, 5'd2);
        step();
        nop();
        @(negedge clk);
        chk("pre_rst_wb", 8'({wb_valid, wb_dst}), {3'b001, 5'd14});
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 8'({ex_valid, mem_valid, wb_valid, wb_regWrite}), 8'd0);
        chk("mid_rst_dst", 8'(wb_dst), 8'd0);
        chk("mid_rst_fwd", 8'({fwd_a, fwd_b, stall, branch_taken}), 8'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_wb", 8'({wb_valid, wb_regWrite, mem_valid}), 8'd0);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
